// File: rtl/fetch_queue_pkg.sv
// fetch_pkg: shared fetch-entry type and fetch-stage constants
package fetch_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] FETCH_RESET_PC = '0;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcp4;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: redirect, instruction-memory and decode-handshake bundle of the fetch stage
interface fetch_queue_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
);
    logic                     redirect_valid;
    logic [WIDTH-1:0]         redirect_pc;
    logic [WIDTH-1:0]         imem_addr;
    logic [WIDTH-1:0]         imem_rdata;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         out_instr;
    logic [WIDTH-1:0]         out_pc;
    logic [WIDTH-1:0]         out_pcp4;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output redirect_valid, redirect_pc, imem_rdata, out_ready,
        input  imem_addr, out_valid, out_instr, out_pc, out_pcp4, count
    );

    modport slave (
        input  redirect_valid, redirect_pc, imem_rdata, out_ready,
        output imem_addr, out_valid, out_instr, out_pc, out_pcp4, count
    );
endinterface

// File: rtl/fetch_queue_fifo.sv
// fetch_fifo: synchronous FIFO of fetch entries with push/pop/clear and occupancy count
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_clear,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  fetch_entry_t           i_data,
    output fetch_entry_t           o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    fetch_entry_t r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;

    // Entry storage; zeroed on reset so the head reads as 0 before the first push
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_push && !i_clear) begin
            r_mem[r_wr] <= i_data;
        end
    end

    // Pointers wrap naturally; the count is what tells full from empty
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + 1'b1;
            if (i_pop) r_rd <= r_rd + 1'b1;
            r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
        end
    end

    assign o_data  = r_mem[r_rd];
    assign o_full  = r_count == (AW+1)'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_count = r_count;
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: sequential-PC fetch stage with decoupling queue to decode; FETCH_BYPASS_EN enables same-cycle bypass when empty
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = XLEN,
    parameter int               DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = FETCH_RESET_PC
) (
    input  logic         clk,
    input  logic         rst,
    fetch_queue_if.slave bus
);
    logic [WIDTH-1:0]       r_pc;
    fetch_entry_t           w_in;
    fetch_entry_t           w_head;
    fetch_entry_t           w_out;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_byp;
    logic                   w_push;
    logic                   w_pop;
    logic [$clog2(DEPTH):0] w_count;

    assign w_in = '{instr: bus.imem_rdata, pc: r_pc, pcp4: r_pc + WIDTH'(4)};

`ifdef FETCH_BYPASS_EN
    assign w_byp = w_empty && !rst && !bus.redirect_valid;
`else
    assign w_byp = 1'b0;
`endif

    // A redirect hides the head so decode never accepts a wrong-path entry
    assign bus.out_valid = !rst && !bus.redirect_valid && (!w_empty || w_byp);
    assign w_pop  = bus.out_valid && bus.out_ready;
    assign w_push = !bus.redirect_valid && (!w_full || w_pop);
    assign w_out  = w_byp ? w_in : w_head;

    // Fetch PC: reset beats redirect, redirect beats sequential advance
    always_ff @(posedge clk) begin
        if (rst) r_pc <= RESET_PC;
        else if (bus.redirect_valid) r_pc <= bus.redirect_pc;
        else if (w_push) r_pc <= r_pc + WIDTH'(4);
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_clear (bus.redirect_valid),
        .i_push  (w_push && !(w_byp && bus.out_ready)),
        .i_pop   (w_pop && !w_empty),
        .i_data  (w_in),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign bus.imem_addr = r_pc;
    assign bus.out_instr = w_out.instr;
    assign bus.out_pc    = w_out.pc;
    assign bus.out_pcp4  = w_out.pcp4;
    assign bus.count     = w_count;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed self-checking bench for fetch_queue (DEPTH=4, RESET_PC=0)
module tb_fetch_queue;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    fetch_queue_if #(.WIDTH(32), .DEPTH(4)) bus ();

    fetch_queue #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    assign bus.imem_rdata = mem_word(bus.imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_vec++; if (bus.imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr got %h want 0", bus.imem_addr); end
        n_vec++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", bus.count); end
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
        n_vec++; if ({bus.out_instr, bus.out_pc, bus.out_pcp4} !== 96'h0) begin n_err++; $display("FAIL reset_outs got %h/%h/%h want 0", bus.out_instr, bus.out_pc, bus.out_pcp4); end
        rst = 1'b0;
    endtask

    task automatic test_stream();
        do_reset();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            logic [31:0] epc;
            epc = BYP ? 32'(4 * k) : 32'(4 * (k - 1));
            #1;
            n_vec++; if (bus.imem_addr !== 32'(4 * k)) begin n_err++; $display("FAIL stream_addr k=%0d got %h want %h", k, bus.imem_addr, 32'(4 * k)); end
            if (BYP || k > 0) begin
                n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid k=%0d got %b want 1", k, bus.out_valid); end
                n_vec++; if (bus.out_pc !== epc || bus.out_pcp4 !== epc + 32'd4 || bus.out_instr !== mem_word(epc)) begin
                    n_err++; $display("FAIL stream_entry k=%0d got pc=%h pcp4=%h instr=%h want pc=%h", k, bus.out_pc, bus.out_pcp4, bus.out_instr, epc);
                end
                n_vec++; if (bus.count !== (BYP ? 3'd0 : 3'd1)) begin n_err++; $display("FAIL stream_count k=%0d got %0d want %0d", k, bus.count, BYP ? 0 : 1); end
            end else begin
                n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL stream_valid0 got %b want 0", bus.out_valid); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall_full();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            #1;
            n_vec++; if (bus.count !== 3'(k < 4 ? k : 4)) begin n_err++; $display("FAIL stall_count k=%0d got %0d want %0d", k, bus.count, k < 4 ? k : 4); end
            n_vec++; if (bus.imem_addr !== 32'(k < 4 ? 4 * k : 16)) begin n_err++; $display("FAIL stall_addr k=%0d got %h want %h", k, bus.imem_addr, 32'(k < 4 ? 4 * k : 16)); end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            #1;
            n_vec++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(4 * j) || bus.out_pcp4 !== 32'(4 * j + 4)) begin
                n_err++; $display("FAIL drain_entry j=%0d got v=%b pc=%h pcp4=%h want pc=%h", j, bus.out_valid, bus.out_pc, bus.out_pcp4, 32'(4 * j));
            end
            n_vec++; if (bus.count !== 3'd4) begin n_err++; $display("FAIL full_count j=%0d got %0d want 4", j, bus.count); end
            n_vec++; if (bus.imem_addr !== 32'(16 + 4 * j)) begin n_err++; $display("FAIL full_addr j=%0d got %h want %h", j, bus.imem_addr, 32'(16 + 4 * j)); end
            @(negedge clk);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        repeat (3) @(negedge clk);
        #1;
        n_vec++; if (bus.count !== 3'd3) begin n_err++; $display("FAIL redir_pre_count got %0d want 3", bus.count); end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h100;
        bus.out_ready = 1'b1;
        #1;
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL redir_valid got %b want 0", bus.out_valid); end
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #1;
        n_vec++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL redir_count got %0d want 0", bus.count); end
        n_vec++; if (bus.imem_addr !== 32'h100) begin n_err++; $display("FAIL redir_addr got %h want 100", bus.imem_addr); end
        n_vec++; if (bus.out_valid !== BYP || (BYP && bus.out_pc !== 32'h100)) begin
            n_err++; $display("FAIL redir_r1 got v=%b pc=%h want v=%b", bus.out_valid, bus.out_pc, BYP);
        end
        @(negedge clk);
        #1;
        n_vec++; if (bus.out_valid !== 1'b1 || bus.out_pc !== (BYP ? 32'h104 : 32'h100)) begin
            n_err++; $display("FAIL redir_first got v=%b pc=%h want pc=%h", bus.out_valid, bus.out_pc, BYP ? 32'h104 : 32'h100);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h203;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #1;
        n_vec++; if (bus.imem_addr !== 32'h203) begin n_err++; $display("FAIL redir_unaligned got %h want 203", bus.imem_addr); end
        @(negedge clk);
    endtask

    task automatic test_reset_over_redirect();
        do_reset();
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h300;
        @(negedge clk);
        #1;
        n_vec++; if (bus.imem_addr !== 32'h0) begin n_err++; $display("FAIL rstredir_addr got %h want 0", bus.imem_addr); end
        n_vec++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL rstredir_count got %0d want 0", bus.count); end
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rstredir_valid got %b want 0", bus.out_valid); end
        rst = 1'b0;
        bus.redirect_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_stream();
        test_stall_full();
        test_redirect();
        test_reset_over_redirect();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
